// File: rtl/bitdemux_fill.sv
// rtl/bitdemux_fill.sv - sequential 1-to-N bit demux that assembles an N-bit word from single-bit beats
// Optional sticky overwrite/out-of-range error port: define BITDEMUX_OVERWRITE_ERR_EN.
module bitdemux_fill #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in,
  input  logic [SW-1:0] sel,
  input  logic          auto,
  input  logic          clr,
  output logic [N-1:0]  out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  mask
`ifdef BITDEMUX_OVERWRITE_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [SW-1:0] LP_PTR_LAST = SW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_out;
  logic [N-1:0]  r_mask;
  logic [SW-1:0] r_ptr;

  logic [SW-1:0] w_tgt;
  logic [N-1:0]  w_onehot;
  logic [N-1:0]  w_mask_upd;
  logic          w_accept;
  logic          w_complete;
  logic          w_out_hs;

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_FULL);
  assign out       = r_out;
  assign mask      = r_mask;

  assign w_tgt = auto ? r_ptr : sel;

  // An out-of-range target decodes to an all-zero one-hot, so the beat is dropped naturally.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_onehot[i] = (w_tgt == SW'(i));
    end
  end

  assign w_mask_upd = r_mask | w_onehot;
  assign w_accept   = in_valid && in_ready && !clr;
  assign w_complete = w_accept && (&w_mask_upd);
  assign w_out_hs   = out_valid && out_ready && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FILL:  if (w_complete) w_state_nxt = S_FULL;
      S_FULL:  if (w_out_hs)   w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
    if (clr) begin
      w_state_nxt = S_FILL;
    end
  end

  // The assembled word is deliberately kept across clr and output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_mask <= '0;
      r_ptr  <= '0;
    end else if (clr || w_out_hs) begin
      r_mask <= '0;
      r_ptr  <= '0;
    end else if (w_accept) begin
      r_mask <= w_mask_upd;
      r_out  <= (r_out & ~w_onehot) | ({N{in}} & w_onehot);
      if (auto) begin
        r_ptr <= (r_ptr == LP_PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
    end
  end

`ifdef BITDEMUX_OVERWRITE_ERR_EN
  localparam logic [SW:0] LP_N = (SW + 1)'(N);

  logic r_err;
  logic w_tgt_ok;
  logic w_err_hit;

  assign w_tgt_ok  = ({1'b0, w_tgt} < LP_N);
  assign w_err_hit = w_accept && (!w_tgt_ok || (|(r_mask & w_onehot)));
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
    end else if (w_err_hit) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bitdemux_fill.sv
// tb/tb_bitdemux_fill.sv - checks bitdemux_fill (N=8 and N=5) with vector tables, directed sequences and a random model run
module tb_bitdemux_fill;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_iv, t_in, t_au, t_cl, t_ordy;
  logic [2:0] t_sel;

  logic       o8_ir, o8_ov, err8;
  logic [7:0] o8_out, o8_mask;
  logic       o5_ir, o5_ov, err5;
  logic [4:0] o5_out, o5_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitdemux_fill #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv), .in_ready(o8_ir), .in(t_in),
    .sel(t_sel), .auto(t_au), .clr(t_cl), .out(o8_out), .out_valid(o8_ov),
    .out_ready(t_ordy), .mask(o8_mask)
`ifdef BITDEMUX_OVERWRITE_ERR_EN
    , .err(err8)
`endif
  );

  bitdemux_fill #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv), .in_ready(o5_ir), .in(t_in),
    .sel(t_sel), .auto(t_au), .clr(t_cl), .out(o5_out), .out_valid(o5_ov),
    .out_ready(t_ordy), .mask(o5_mask)
`ifdef BITDEMUX_OVERWRITE_ERR_EN
    , .err(err5)
`endif
  );

`ifndef BITDEMUX_OVERWRITE_ERR_EN
  assign err8 = 1'b0;
  assign err5 = 1'b0;
`endif

  // Reference model: index 0 is the N=8 instance, index 1 the N=5 instance.
  int         mn[2] = '{8, 5};
  logic [7:0] m_out[2];
  logic [7:0] m_wr[2];
  int         m_ptr[2];
  bit         m_full[2];
  bit         m_err[2];

  typedef struct {
    logic       iv, din, au, ordy;
    logic [2:0] sl;
    logic [7:0] e_out, e_mask;
    logic       e_ov, e_ir, e_err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic iv, logic din, logic au, logic ordy, logic [2:0] sl,
                              logic [7:0] eo, logic [7:0] em, logic eov, logic eir, logic eerr);
    vec_t v;
    v.iv = iv; v.din = din; v.au = au; v.ordy = ordy; v.sl = sl;
    v.e_out = eo; v.e_mask = em; v.e_ov = eov; v.e_ir = eir; v.e_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0; m_wr[k] = '0; m_ptr[k] = 0; m_full[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    int t;
    for (int k = 0; k < 2; k++) begin
      if (t_cl) begin
        m_wr[k] = '0; m_ptr[k] = 0; m_full[k] = 0; m_err[k] = 0;
      end else if (m_full[k]) begin
        if (t_ordy) begin
          m_full[k] = 0; m_wr[k] = '0; m_ptr[k] = 0;
        end
      end else if (t_iv) begin
        t = t_au ? m_ptr[k] : int'(t_sel);
        if (t < mn[k]) begin
          if (m_wr[k][t]) m_err[k] = 1;
          m_out[k][t] = t_in;
          m_wr[k][t]  = 1'b1;
        end else begin
          m_err[k] = 1;
        end
        if (t_au) m_ptr[k] = (m_ptr[k] + 1) % mn[k];
        if (m_wr[k] == 8'((1 << mn[k]) - 1)) m_full[k] = 1;
      end
    end
  endtask

  task automatic cmp_inst(input string p, input int k, input logic [7:0] aout, input logic [7:0] amask,
                          input logic aov, input logic air, input logic aerr);
    check({p, ".out"},       32'(aout),  32'(m_out[k]));
    check({p, ".mask"},      32'(amask), 32'(m_wr[k]));
    check({p, ".out_valid"}, 32'(aov),   32'(m_full[k]));
    check({p, ".in_ready"},  32'(air),   32'(!m_full[k]));
`ifdef BITDEMUX_OVERWRITE_ERR_EN
    check({p, ".err"},       32'(aerr),  32'(m_err[k]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_inst("m8", 0, o8_out, o8_mask, o8_ov, o8_ir, err8);
    cmp_inst("m5", 1, {3'b0, o5_out}, {3'b0, o5_mask}, o5_ov, o5_ir, err5);
  endtask

  task automatic set_in(input logic iv, input logic din, input logic au, input logic [2:0] sl,
                        input logic cl, input logic ordy);
    t_iv = iv; t_in = din; t_au = au; t_sel = sl; t_cl = cl; t_ordy = ordy;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] snap5;

    // word A: auto fill with 1,0,1,1,0,0,1,0 then drain
    tbl[0]  = mk(1, 1, 1, 0, 0, 8'h01, 8'h01, 0, 1, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 8'h01, 8'h03, 0, 1, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 8'h05, 8'h07, 0, 1, 0);
    tbl[3]  = mk(1, 1, 1, 0, 0, 8'h0D, 8'h0F, 0, 1, 0);
    tbl[4]  = mk(1, 0, 1, 0, 0, 8'h0D, 8'h1F, 0, 1, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0, 8'h0D, 8'h3F, 0, 1, 0);
    tbl[6]  = mk(1, 1, 1, 0, 0, 8'h4D, 8'h7F, 0, 1, 0);
    tbl[7]  = mk(1, 0, 1, 0, 0, 8'h4D, 8'hFF, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 0, 8'h4D, 8'h00, 0, 1, 0);
    // word B: explicit selects 7,0,3,3(in=0),1,2,4,5,6 on top of the retained 0x4D
    tbl[9]  = mk(1, 1, 0, 0, 7, 8'hCD, 8'h80, 0, 1, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 8'hCD, 8'h81, 0, 1, 0);
    tbl[11] = mk(1, 1, 0, 0, 3, 8'hCD, 8'h89, 0, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 3, 8'hC5, 8'h89, 0, 1, 1);
    tbl[13] = mk(1, 1, 0, 0, 1, 8'hC7, 8'h8B, 0, 1, 1);
    tbl[14] = mk(1, 1, 0, 0, 2, 8'hC7, 8'h8F, 0, 1, 1);
    tbl[15] = mk(1, 1, 0, 0, 4, 8'hD7, 8'h9F, 0, 1, 1);
    tbl[16] = mk(1, 1, 0, 0, 5, 8'hF7, 8'hBF, 0, 1, 1);
    tbl[17] = mk(1, 1, 0, 0, 6, 8'hF7, 8'hFF, 1, 0, 1);
    tbl[18] = mk(0, 0, 0, 1, 0, 8'hF7, 8'h00, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 8'hF7, 8'h00, 0, 1, 1);

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst.out",       32'(o8_out),  32'h0);
    check("rst.mask",      32'(o8_mask), 32'h0);
    check("rst.out_valid", 32'(o8_ov),   32'h0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready",  32'(o8_ir),   32'h1);
    check("rst.err",       32'(err8),    32'h0);

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].iv, tbl[i].din, tbl[i].au, tbl[i].sl, 0, tbl[i].ordy);
      tick();
      check($sformatf("tbl%0d.out", i),       32'(o8_out),  32'(tbl[i].e_out));
      check($sformatf("tbl%0d.mask", i),      32'(o8_mask), 32'(tbl[i].e_mask));
      check($sformatf("tbl%0d.out_valid", i), 32'(o8_ov),   32'(tbl[i].e_ov));
      check($sformatf("tbl%0d.in_ready", i),  32'(o8_ir),   32'(tbl[i].e_ir));
`ifdef BITDEMUX_OVERWRITE_ERR_EN
      check($sformatf("tbl%0d.err", i),       32'(err8),    32'(tbl[i].e_err));
`endif
    end

    // clr clears err; then 4 auto beats, then clr racing an input beat
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    check("clr.err", 32'(err8), 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 1, 0, 0, 0);
      tick();
    end
    check("pre_clr.out", 32'(o8_out), 32'hFF);
    set_in(1, 0, 1, 0, 1, 0);
    tick();
    check("clr_beat.out",      32'(o8_out),  32'hFF);
    check("clr_beat.mask",     32'(o8_mask), 32'h00);
    check("clr_beat.in_ready", 32'(o8_ir),   32'h1);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      set_in(1, pat[i], 1, 0, 0, 0);
      tick();
    end
    check("after_clr.out",       32'(o8_out),  32'hA5);
    check("after_clr.mask",      32'(o8_mask), 32'hFF);
    check("after_clr.out_valid", 32'(o8_ov),   32'h1);

    // FULL with back-pressure and a pending input beat
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 1, 0, 0, 0);
      tick();
      check($sformatf("stall%0d.out", i),      32'(o8_out),  32'hA5);
      check($sformatf("stall%0d.mask", i),     32'(o8_mask), 32'hFF);
      check($sformatf("stall%0d.in_ready", i), 32'(o8_ir),   32'h0);
    end
    set_in(1, 0, 1, 0, 0, 1);
    tick();
    check("drain.out_valid", 32'(o8_ov),   32'h0);
    check("drain.in_ready",  32'(o8_ir),   32'h1);
    check("drain.mask",      32'(o8_mask), 32'h00);
    set_in(1, 0, 1, 0, 0, 0);
    tick();
    check("first_beat.mask", 32'(o8_mask), 32'h01);
    check("first_beat.out",  32'(o8_out),  32'hA4);

    // N=5 out-of-range select
    set_in(0, 0, 0, 0, 1, 0);
    tick();
    snap5 = m_out[1];
    check("oor.in_ready", 32'(o5_ir), 32'h1);
    set_in(1, 1, 0, 3'd6, 0, 0);
    tick();
    check("oor.mask", 32'(o5_mask), 32'h0);
    check("oor.out",  32'(o5_out),  32'(snap5[4:0]));
`ifdef BITDEMUX_OVERWRITE_ERR_EN
    check("oor.err",  32'(err5),    32'h1);
`endif

    // asynchronous reset mid-word
    set_in(1, 1, 1, 0, 0, 0);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.out",       32'(o8_out),  32'h0);
    check("arst.mask",      32'(o8_mask), 32'h0);
    check("arst.out_valid", 32'(o8_ov),   32'h0);
    check("arst5.out",      32'(o5_out),  32'h0);
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;

    repeat (600) begin
      set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
             3'($urandom_range(0, 7)), $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitdemux_fill.md
Name: bitdemux_fill

Overview:
- Sequential 1-to-N bit demultiplexer; the write-side counterpart of the N:1 single-bit mux.
- Accepts one bit per valid/ready handshake and steers it into a selected position of an N-bit holding register.
- Positions come from an explicit select or an internal auto-increment pointer.
- Once every position has been written, presents the assembled word on an output valid/ready handshake.
- Used in the datapath for bit-serial assembly of CSR/immediate fields.

Parameters:
- N, 8, output word width and number of bit positions; legal range N >= 2, any value (not restricted to powers of 2).
- SW, $clog2(N), select width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input bit valid.
- in_ready  output  1  block can accept a bit.
- in  input  1  data bit.
- sel  input  SW  target position when auto=0.
- auto  input  1  1: use internal pointer ptr, ignore sel.
- clr  input  1  synchronous abort; discards partial word.
- out  output  N  assembled word.
- out_valid  output  1  word complete.
- out_ready  input  1  consumer accepts word.
- mask  output  N  per-position written flags.

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, mask=0, ptr=0, state=FILL, out_valid=0, in_ready=1 (once reset releases).
- States: FILL, FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - An input beat is accepted when in_valid && in_ready.
  - Target index t = auto ? ptr : sel.
  - If t < N: out[t] <= in and mask[t] <= 1 on the accepting edge.
  - If t >= N (only possible when N is not a power of 2): beat is accepted and dropped; out and mask are unchanged.
  - ptr increments on every accepted beat with auto=1, wrapping from N-1 to 0; ptr is unchanged for auto=0 beats.
  - Rewriting an already-written position overwrites out[t]; mask[t] stays 1.
- FILL -> FULL:
  - Taken on the edge where mask would become all-ones, including the new write.
  - out_valid goes high the cycle after the completing beat (1-cycle latency).
- FULL:
  - in_ready=0, out_valid=1; out and mask are held stable.
  - Handshake out_valid && out_ready: mask <= 0, ptr <= 0, state <= FILL.
  - out keeps its value; positions are overwritten on subsequent writes.
  - in_ready returns high the cycle after the output handshake; there is no same-cycle input/output overlap.
- clr (synchronous, highest priority after reset):
  - mask <= 0, ptr <= 0, state <= FILL.
  - Any concurrent input beat or output handshake is ignored.
  - out is not cleared.
- in_valid may be held with in_ready=0; the beat is taken once in_ready rises.
- Mixed auto/sel beats within one word are legal; ptr counts auto beats only.
- Reset mid-word or in FULL returns to the reset values immediately.

Optional Feature:
- Macro BITDEMUX_OVERWRITE_ERR_EN.
- When defined:
  - Adds output port err (1 bit).
  - err is a sticky flag, reset 0.
  - Set on any accepted beat whose target t has mask[t]=1 already, or whose t >= N.
  - Cleared only by clr or reset; the data behaviour is unchanged.
- When undefined: no err port and no error logic; overwrites and out-of-range beats are silent.

Test Plan:
- N=8, auto=1: send bits 1,0,1,1,0,0,1,0 back-to-back.
  - Response: out_valid rises one cycle after beat 8; out=8'b0100_1101; in_ready=0 while out_valid=1.
  - With out_ready=1: out_valid falls and in_ready rises next cycle; mask=0.
- N=8, auto=0, sel order 7,0,3,3(in=0),1,2,4,5,6, each with in=1 except the repeat.
  - Response: completes on the sel=6 beat; out=8'b1111_0111.
  - With BITDEMUX_OVERWRITE_ERR_EN: err=1 after the second sel=3 beat.
- N=5, auto=0, sel=6, in=1.
  - Response: beat accepted (in_ready=1); mask and out unchanged.
  - err=1 if the feature is enabled.
- N=8, auto=1: write 4 bits, then pulse clr together with in_valid.
  - Response: mask=0, ptr=0; the concurrent beat is not written.
  - The next 8 beats complete a word normally.
- FULL with out_ready=0 for 5 cycles while in_valid=1.
  - Response: out and mask stable, no beat accepted.
  - On out_ready=1: handshake completes; the first new beat is accepted the following cycle.
- Assert rst_n=0 mid-word, asynchronously between edges.
  - Response: out=0, mask=0, out_valid=0 immediately, without waiting for a clock edge.
